// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet header parser pipeline.
package eth_parser_pkg;

    typedef logic [7:0] byte_t;

    localparam int ETH_HDR_BYTES     = 18;
    localparam int ETH_MIN_HDR_BYTES = 14;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        EMIT    = 2'd1,
        DRAIN   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/eth_header_capture.sv
// Captures the first HDR_BYTES bytes of each frame and pulses header_valid.
// Optional ETH_HDR_CAPTURE_STATS_EN adds frame_cnt / runt_cnt statistics outputs.
module eth_header_capture
    import eth_parser_pkg::*;
#(
    parameter int HDR_BYTES     = ETH_HDR_BYTES,
    parameter int MIN_HDR_BYTES = ETH_MIN_HDR_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  byte_t      in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output byte_t      header_bytes [0:HDR_BYTES-1],
    output logic       header_valid,
    output logic [4:0] hdr_len,
    output logic       runt_err
`ifdef ETH_HDR_CAPTURE_STATS_EN
    ,
    output logic [31:0] frame_cnt,
    output logic [15:0] runt_cnt
`endif
);

    localparam logic [4:0] LAST_IDX = 5'(HDR_BYTES - 1);
    localparam logic [4:0] MIN_LEN  = 5'(MIN_HDR_BYTES);
    localparam logic [4:0] FULL_LEN = 5'(HDR_BYTES);

    cap_state_t state_r;
    cap_state_t state_s;
    logic [4:0] cnt_r;
    logic [4:0] cnt_s;
    logic       drain_r;
    logic       drain_s;
    logic       emit_s;
    logic       runt_s;
    logic [4:0] len_s;
    logic       accept_s;
    // Bytes land in a private buffer so a runt never disturbs the published header.
    byte_t      cap_r [0:HDR_BYTES-1];

    assign in_ready = (state_r != EMIT);
    assign accept_s = in_valid && in_ready;

    // Next-state, counter and pulse decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        drain_s = drain_r;
        emit_s  = 1'b0;
        runt_s  = 1'b0;
        len_s   = hdr_len;
        case (state_r)
            CAPTURE: begin
                if (accept_s) begin
                    if (cnt_r == LAST_IDX) begin
                        state_s = EMIT;
                        cnt_s   = 5'd0;
                        drain_s = !in_last;
                        emit_s  = 1'b1;
                        len_s   = FULL_LEN;
                    end else if (in_last) begin
                        cnt_s = 5'd0;
                        if ((cnt_r + 5'd1) >= MIN_LEN) begin
                            state_s = EMIT;
                            drain_s = 1'b0;
                            emit_s  = 1'b1;
                            len_s   = cnt_r + 5'd1;
                        end else begin
                            runt_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            EMIT: begin
                state_s = drain_r ? DRAIN : CAPTURE;
            end
            DRAIN: begin
                if (accept_s && in_last) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = CAPTURE;
            end
        endcase
    end

    // State, capture buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= CAPTURE;
            cnt_r        <= 5'd0;
            drain_r      <= 1'b0;
            header_valid <= 1'b0;
            runt_err     <= 1'b0;
            hdr_len      <= 5'd0;
            for (int i = 0; i < HDR_BYTES; i++) begin
                cap_r[i]        <= 8'h00;
                header_bytes[i] <= 8'h00;
            end
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            drain_r      <= drain_s;
            header_valid <= emit_s;
            runt_err     <= runt_s;
            hdr_len      <= len_s;
            if (state_r == CAPTURE && accept_s) begin
                cap_r[cnt_r] <= in_data;
            end
            // Publish: earlier bytes from the buffer, the completing byte live, tail zeroed.
            if (emit_s) begin
                for (int i = 0; i < HDR_BYTES; i++) begin
                    if (5'(i) < cnt_r) begin
                        header_bytes[i] <= cap_r[i];
                    end else if (5'(i) == cnt_r) begin
                        header_bytes[i] <= in_data;
                    end else begin
                        header_bytes[i] <= 8'h00;
                    end
                end
            end
        end
    end

`ifdef ETH_HDR_CAPTURE_STATS_EN
    // Free-running statistics counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= 32'd0;
            runt_cnt  <= 16'd0;
        end else begin
            if (header_valid) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (runt_err) begin
                runt_cnt <= runt_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
